micro_sequencer: RTL and testbench
==================================

Name: micro_sequencer

Overview:
- Next-state generator for the microprogrammed control unit; sits directly downstream of the instruction-to-state encoder.
- Holds the current control-state register, which addresses the microstore.
- Each cycle it picks the next state: sequential increment, dispatch to the encoder's State_Sel, jump, conditional jump, or a timed wait on memory-operation-complete (MOC).
- Jump and wait timeouts divert to a fault state.

Parameters:
- STATE_W, 7, width of state address.
- FETCH_STATE, 1, state entered on return-to-fetch and encoder default.
- RESET_STATE, 0, state loaded on reset.
- FAULT_STATE, 127, state entered on MOC timeout or out-of-range state.
- MAX_STATE, 63, highest legal state; anything above (except FAULT_STATE) is illegal.
- MOC_TIMEOUT, 15, max cycles spent waiting for MOC before fault (1..255).

Ports:
- Clk  in  1  clock; all state changes on rising edge.
- Reset_n  in  1  synchronous active-low reset.
- State_Sel  in  STATE_W  dispatch target from instruction encoder.
- Next_Ctl  in  3  microword next-address control for current state.
- Jump_Addr  in  STATE_W  microword jump target.
- Cond_Sel  in  2  condition select: 0=Zero, 1=Neg, 2=MOC, 3=Cond_Ext.
- Cond_Inv  in  1  invert selected condition.
- Zero  in  1  ALU zero flag.
- Neg  in  1  ALU sign flag.
- MOC  in  1  memory operation complete.
- Cond_Ext  in  1  spare condition input.
- Stall  in  1  hold current state (no advance, wait counter frozen).
- State  out  STATE_W  current control state (registered).
- Dispatched  out  1  one-cycle pulse: the cycle after a dispatch was taken.
- Waiting  out  1  high while in a MOC wait that has not completed.
- Fault  out  1  sticky; set on timeout or illegal state, cleared only by reset.

Behaviour:
- Reset (Reset_n=0 at edge): State=RESET_STATE, Dispatched=0, Waiting=0, Fault=0, wait counter=0. Reset wins over every other input, including mid-wait.
- Next_Ctl encodings, evaluated on current State:
  - 0 INC: State+1.
  - 1 DISPATCH: State_Sel; Dispatched=1 next cycle.
  - 2 JUMP: Jump_Addr.
  - 3 CJUMP: if (cond XOR Cond_Inv) then Jump_Addr, else State+1.
  - 4 WAITMOC: if MOC=1 then State+1 and counter cleared; else hold State and counter+1. Waiting=1 combinationally whenever Next_Ctl=4 and MOC=0.
  - 5 FETCH: FETCH_STATE.
  - 6, 7: treated as FETCH.
- Timeout: while in WAITMOC with MOC=0, when counter reaches MOC_TIMEOUT, the next edge loads FAULT_STATE, sets Fault, and clears the counter. With MOC_TIMEOUT=15, fault occurs at the 16th consecutive MOC-low edge.
- MOC rising on the same edge as the timeout wins: State+1 is taken, no fault.
- Counter clears on any edge where Next_Ctl≠4.
- Stall=1: State, counter and Dispatched hold.
  - Stall has priority over everything except reset.
  - Dispatched is forced 0 during stall.
- Increment wrap: State+1 is computed modulo 2^STATE_W.
  - If the result exceeds MAX_STATE and is not FAULT_STATE, load FAULT_STATE and set Fault.
  - The same check applies to dispatch and jump targets.
- In FAULT_STATE the sequencer obeys Next_Ctl normally; the microstore places recovery code there.
- Latency: one cycle from inputs to State.

Test Plan:
- Reset: hold Reset_n=0 for 2 cycles with Next_Ctl=2, Jump_Addr=9 -> State=0, Fault=0, Dispatched=0; release with Next_Ctl=0 -> State=1.
- Dispatch: State=1, Next_Ctl=1, State_Sel=13 -> next State=13, Dispatched=1 for exactly one cycle; with Stall=1 on that edge -> State stays 1, Dispatched=0.
- Conditional jump: Next_Ctl=3, Cond_Sel=0, Zero=1, Cond_Inv=0, Jump_Addr=40, State=11 -> State=40; repeat with Cond_Inv=1 -> State=12.
- MOC wait: State=13, Next_Ctl=4, MOC low 5 cycles then high -> State holds 13 with Waiting=1 for 5 cycles, then State=14 and Waiting=0.
- Timeout: MOC held 0 with MOC_TIMEOUT=15 -> State=127 and Fault=1 after 16 edges; MOC=1 on the 16th edge instead -> State=14, Fault=0.
- Illegal: State=63, Next_Ctl=0 -> State=127, Fault=1; Reset_n pulse -> Fault=0, State=0.

Source files
------------

// File: rtl/micro_sequencer.sv
// Next-state generator for the microprogrammed control unit: one-cycle latency from inputs to State.
// Stall freezes State and the wait counter; jump/increment overflow and MOC wait timeout divert to FAULT_STATE.
module micro_sequencer #(
   parameter int STATE_W     = 7,
   parameter int FETCH_STATE = 1,
   parameter int RESET_STATE = 0,
   parameter int FAULT_STATE = 127,
   parameter int MAX_STATE   = 63,
   parameter int MOC_TIMEOUT = 15
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic [STATE_W-1:0] State_Sel,
   input  logic [2:0]         Next_Ctl,
   input  logic [STATE_W-1:0] Jump_Addr,
   input  logic [1:0]         Cond_Sel,
   input  logic               Cond_Inv,
   input  logic               Zero,
   input  logic               Neg,
   input  logic               MOC,
   input  logic               Cond_Ext,
   input  logic               Stall,
   output logic [STATE_W-1:0] State,
   output logic               Dispatched,
   output logic               Waiting,
   output logic               Fault
);

   localparam logic [2:0] NC_INC      = 3'd0;
   localparam logic [2:0] NC_DISPATCH = 3'd1;
   localparam logic [2:0] NC_JUMP     = 3'd2;
   localparam logic [2:0] NC_CJUMP    = 3'd3;
   localparam logic [2:0] NC_WAITMOC  = 3'd4;

   localparam logic [STATE_W-1:0] FETCH_S = STATE_W'(FETCH_STATE);
   localparam logic [STATE_W-1:0] RESET_S = STATE_W'(RESET_STATE);
   localparam logic [STATE_W-1:0] FAULT_S = STATE_W'(FAULT_STATE);
   localparam logic [STATE_W-1:0] MAX_S   = STATE_W'(MAX_STATE);
   localparam logic [7:0]         TMO     = 8'(MOC_TIMEOUT);

   logic [STATE_W-1:0] inc_state;
   logic [STATE_W-1:0] raw_next;
   logic               range_chk;
   logic               take_disp;
   logic               cond;
   logic               illegal;
   logic               timeout;
   logic               wait_miss;
   logic [7:0]         wait_cnt;

   always_comb begin
      inc_state = State + STATE_W'(1);
      raw_next  = inc_state;
      range_chk = 1'b1;
      take_disp = 1'b0;
      cond      = 1'b0;
      case (Cond_Sel)
         2'd0:    cond = Zero;
         2'd1:    cond = Neg;
         2'd2:    cond = MOC;
         default: cond = Cond_Ext;
      endcase
      case (Next_Ctl)
         NC_INC:      raw_next = inc_state;
         NC_DISPATCH: begin
            raw_next  = State_Sel;
            take_disp = 1'b1;
         end
         NC_JUMP:     raw_next = Jump_Addr;
         NC_CJUMP:    raw_next = (cond ^ Cond_Inv) ? Jump_Addr : inc_state;
         NC_WAITMOC:  raw_next = MOC ? inc_state : State;
         default: begin
            raw_next  = FETCH_S;
            range_chk = 1'b0;
         end
      endcase
      illegal   = range_chk && (raw_next > MAX_S) && (raw_next != FAULT_S);
      wait_miss = (Next_Ctl == NC_WAITMOC) && !MOC;
      // MOC arriving on the timeout edge suppresses the timeout via wait_miss
      timeout   = wait_miss && (wait_cnt == TMO);
   end

   assign Waiting = wait_miss;

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         State      <= RESET_S;
         Dispatched <= 1'b0;
         Fault      <= 1'b0;
         wait_cnt   <= 8'd0;
      end else if (Stall) begin
         Dispatched <= 1'b0;
      end else begin
         Dispatched <= take_disp;
         if (timeout || illegal) begin
            State <= FAULT_S;
            Fault <= 1'b1;
         end else begin
            State <= raw_next;
         end
         wait_cnt <= (wait_miss && !timeout) ? wait_cnt + 8'd1 : 8'd0;
      end
   end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed-vector bench for micro_sequencer with hand-computed expected states and flags.
module tb_micro_sequencer;

   logic       Clk = 1'b0;
   logic       Reset_n;
   logic [6:0] State_Sel;
   logic [2:0] Next_Ctl;
   logic [6:0] Jump_Addr;
   logic [1:0] Cond_Sel;
   logic       Cond_Inv;
   logic       Zero;
   logic       Neg;
   logic       MOC;
   logic       Cond_Ext;
   logic       Stall;
   logic [6:0] State;
   logic       Dispatched;
   logic       Waiting;
   logic       Fault;

   int n_vec  = 0;
   int n_miss = 0;

   micro_sequencer dut (
      .Clk(Clk), .Reset_n(Reset_n), .State_Sel(State_Sel), .Next_Ctl(Next_Ctl),
      .Jump_Addr(Jump_Addr), .Cond_Sel(Cond_Sel), .Cond_Inv(Cond_Inv), .Zero(Zero),
      .Neg(Neg), .MOC(MOC), .Cond_Ext(Cond_Ext), .Stall(Stall), .State(State),
      .Dispatched(Dispatched), .Waiting(Waiting), .Fault(Fault)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic jump_to(input logic [6:0] addr);
      Next_Ctl  = 3'd2;
      Jump_Addr = addr;
      step();
   endtask

   initial begin
      Reset_n = 1'b0; State_Sel = '0; Next_Ctl = 3'd2; Jump_Addr = 7'd9;
      Cond_Sel = '0; Cond_Inv = 1'b0; Zero = 1'b0; Neg = 1'b0; MOC = 1'b0;
      Cond_Ext = 1'b0; Stall = 1'b0;

      step(); step();
      chk("rst_state", State, 0);
      chk("rst_fault", Fault, 0);
      chk("rst_disp", Dispatched, 0);

      Reset_n = 1'b1; Next_Ctl = 3'd0;
      step();
      chk("rel_inc", State, 1);

      Next_Ctl = 3'd1; State_Sel = 7'd13; Stall = 1'b1;
      step();
      chk("stall_state", State, 1);
      chk("stall_disp", Dispatched, 0);
      Stall = 1'b0;
      step();
      chk("disp_state", State, 13);
      chk("disp_pulse", Dispatched, 1);
      Next_Ctl = 3'd0;
      step();
      chk("disp_inc", State, 14);
      chk("disp_clear", Dispatched, 0);

      jump_to(7'd11);
      chk("jump11", State, 11);
      Next_Ctl = 3'd3; Cond_Sel = 2'd0; Zero = 1'b1; Cond_Inv = 1'b0; Jump_Addr = 7'd40;
      step();
      chk("cj_taken", State, 40);
      jump_to(7'd11);
      Next_Ctl = 3'd3; Jump_Addr = 7'd40; Cond_Inv = 1'b1;
      step();
      chk("cj_inv", State, 12);
      Cond_Sel = 2'd1; Neg = 1'b0; Cond_Inv = 1'b0;
      step();
      chk("cj_neg_nt", State, 13);

      Next_Ctl = 3'd4; MOC = 1'b0;
      #1;
      chk("wait_comb", Waiting, 1);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("wait_hold", State, 13);
         chk("wait_flag", Waiting, 1);
      end
      MOC = 1'b1;
      #1;
      chk("wait_done_flag", Waiting, 0);
      step();
      chk("wait_adv", State, 14);

      jump_to(7'd13);
      Next_Ctl = 3'd4; MOC = 1'b0;
      for (int i = 0; i < 15; i++) begin
         step();
         chk("tmo_hold", State, 13);
         chk("tmo_nofault", Fault, 0);
      end
      step();
      chk("tmo_state", State, 127);
      chk("tmo_fault", Fault, 1);

      Reset_n = 1'b0;
      step();
      chk("rst2_fault", Fault, 0);
      chk("rst2_state", State, 0);
      Reset_n = 1'b1;

      jump_to(7'd13);
      Next_Ctl = 3'd4; MOC = 1'b0;
      for (int i = 0; i < 15; i++) step();
      MOC = 1'b1;
      step();
      chk("tmo_moc_state", State, 14);
      chk("tmo_moc_fault", Fault, 0);

      jump_to(7'd127);
      chk("jump_fault_legal", State, 127);
      chk("jump_fault_nf", Fault, 0);

      jump_to(7'd63);
      chk("jump63", State, 63);
      Next_Ctl = 3'd0;
      step();
      chk("ill_state", State, 127);
      chk("ill_fault", Fault, 1);
      step();
      chk("wrap_state", State, 0);
      chk("fault_sticky", Fault, 1);
      Next_Ctl = 3'd6;
      step();
      chk("fetch6", State, 1);

      Reset_n = 1'b0;
      step();
      chk("rst3_fault", Fault, 0);
      chk("rst3_state", State, 0);
      Reset_n = 1'b1;

      jump_to(7'd100);
      chk("ill_jump_state", State, 127);
      chk("ill_jump_fault", Fault, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
